cam_core: RTL and testbench

Single-ported-per-direction content-addressable key/value table that serves as the responder behind the CAM arbiter. It accepts one arbitrated update stream and one arbitrated lookup stream, matches lookup keys against all entries in parallel, and returns the stored value tagged with the requester's user ID so the arbiter can route the response. Insertion is self-allocating, with round-robin eviction when the table is full.

---
 rtl/cam_pkg.sv | 22 ++
 rtl/cam_core_match.sv | 22 ++
 rtl/cam_core.sv | 103 ++++++++++
 tb/tb_cam_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared width defaults and helper functions for the CAM core
// Provides default table geometry, the occupancy width function and a
// lowest-set-bit priority encoder (supports tables of up to 64 entries).
package cam_pkg;
    localparam int CAM_TABLE_SIZE  = 16;
    localparam int CAM_KEY_SIZE    = 8;
    localparam int CAM_VALUE_SIZE  = 32;
    localparam int CAM_UPDATE_USER = 4;
    localparam int CAM_LOOKUP_USER = 4;

    function automatic int occ_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int lsb_idx(input logic [63:0] v);
        int r;
        r = 0;
        for (int i = 63; i >= 0; i--)
            if (v[i]) r = i;
        return r;
    endfunction
endpackage

// File: rtl/cam_core_match.sv
// cam_core_match: parallel compare of one key against every valid table entry
// Ports: key (search key), keys/valid (table contents),
//        hit_vec (per-entry match), hit (any match), idx (lowest matching entry).
module cam_core_match
    import cam_pkg::*;
#(
    parameter int TABLE_SIZE = CAM_TABLE_SIZE,
    parameter int KEY_SIZE   = CAM_KEY_SIZE
) (
    input  logic [KEY_SIZE-1:0]                  key,
    input  logic [TABLE_SIZE-1:0][KEY_SIZE-1:0]  keys,
    input  logic [TABLE_SIZE-1:0]                valid,
    output logic [TABLE_SIZE-1:0]                hit_vec,
    output logic                                 hit,
    output logic [$clog2(TABLE_SIZE)-1:0]        idx
);
    for (genvar i = 0; i < TABLE_SIZE; i++) begin : g_cmp
        assign hit_vec[i] = valid[i] && (keys[i] == key);
    end
    assign hit = |hit_vec;
    assign idx = $clog2(TABLE_SIZE)'(lsb_idx(64'(hit_vec)));
endmodule

// File: rtl/cam_core.sv
// cam_core: self-allocating key/value CAM with round-robin eviction when full
// Ports: clk/rst (sync, active-high); update_req_* insert-or-overwrite stream
//        (user accepted, not stored); lookup_req_* search stream; lookup_value_*
//        registered response (data 0 on miss, user echoed); occupancy = valid entries.
// Option: define CAM_CORE_HIT_EN to add the registered lookup_value_hit output.
module cam_core
    import cam_pkg::*;
#(
    parameter int TABLE_SIZE        = CAM_TABLE_SIZE,
    parameter int KEY_SIZE          = CAM_KEY_SIZE,
    parameter int VALUE_SIZE        = CAM_VALUE_SIZE,
    parameter int UPDATE_USER_WIDTH = CAM_UPDATE_USER,
    parameter int LOOKUP_USER_WIDTH = CAM_LOOKUP_USER
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [KEY_SIZE-1:0]            update_req_index,
    input  logic [VALUE_SIZE-1:0]          update_req_data,
    input  logic                           update_req_valid,
    output logic                           update_req_ready,
    input  logic [UPDATE_USER_WIDTH-1:0]   update_req_user,
    input  logic [KEY_SIZE-1:0]            lookup_req_index,
    input  logic                           lookup_req_valid,
    output logic                           lookup_req_ready,
    input  logic [LOOKUP_USER_WIDTH-1:0]   lookup_req_user,
    output logic [VALUE_SIZE-1:0]          lookup_value_data,
    output logic                           lookup_value_valid,
    input  logic                           lookup_value_ready,
    output logic [LOOKUP_USER_WIDTH-1:0]   lookup_value_user,
`ifdef CAM_CORE_HIT_EN
    output logic                           lookup_value_hit,
`endif
    output logic [occ_w(TABLE_SIZE)-1:0]   occupancy
);
    localparam int IW = $clog2(TABLE_SIZE);

    logic [TABLE_SIZE-1:0]                 ent_valid;
    logic [TABLE_SIZE-1:0][KEY_SIZE-1:0]   ent_key;
    logic [TABLE_SIZE-1:0][VALUE_SIZE-1:0] ent_val;
    logic [TABLE_SIZE-1:0]                 upd_vec, lk_vec;
    logic [IW-1:0]                         rp, upd_idx, lk_idx, free_idx, wr_idx;
    logic                                  upd_hit, lk_hit, has_free, upd_fire, lk_fire;
    logic                                  unused_ok;

    cam_core_match #(.TABLE_SIZE(TABLE_SIZE), .KEY_SIZE(KEY_SIZE)) u_upd_match (
        .key(update_req_index), .keys(ent_key), .valid(ent_valid),
        .hit_vec(upd_vec), .hit(upd_hit), .idx(upd_idx)
    );

    cam_core_match #(.TABLE_SIZE(TABLE_SIZE), .KEY_SIZE(KEY_SIZE)) u_lk_match (
        .key(lookup_req_index), .keys(ent_key), .valid(ent_valid),
        .hit_vec(lk_vec), .hit(lk_hit), .idx(lk_idx)
    );

    assign update_req_ready = !rst;
    assign lookup_req_ready = !rst && (!lookup_value_valid || lookup_value_ready);
    assign upd_fire = update_req_valid && update_req_ready;
    assign lk_fire  = lookup_req_valid && lookup_req_ready;
    assign has_free = ~&ent_valid;
    assign free_idx = IW'(lsb_idx(64'(~ent_valid)));
    // Overwrite on hit, else first free slot, else evict the round-robin victim.
    assign wr_idx = upd_hit ? upd_idx : has_free ? free_idx : rp;

    // Lookup reads the pre-edge table, so a same-cycle update is not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid          <= '0;
            rp                 <= '0;
            occupancy          <= '0;
            lookup_value_valid <= 1'b0;
            lookup_value_data  <= '0;
            lookup_value_user  <= '0;
        end else begin
            if (upd_fire) begin
                ent_valid[wr_idx] <= 1'b1;
                ent_key[wr_idx]   <= update_req_index;
                ent_val[wr_idx]   <= update_req_data;
                if (!upd_hit && has_free)
                    occupancy <= occupancy + 1'b1;
                if (!upd_hit && !has_free)
                    rp <= rp + 1'b1;
            end
            if (lookup_req_ready)
                lookup_value_valid <= lookup_req_valid;
            if (lk_fire) begin
                lookup_value_data <= lk_hit ? ent_val[lk_idx] : '0;
                lookup_value_user <= lookup_req_user;
            end
        end
    end

`ifdef CAM_CORE_HIT_EN
    always_ff @(posedge clk) begin
        if (rst)
            lookup_value_hit <= 1'b0;
        else if (lk_fire)
            lookup_value_hit <= lk_hit;
    end
    assign unused_ok = ^{update_req_user, upd_vec, lk_vec};
`else
    assign unused_ok = ^{update_req_user, upd_vec, lk_vec};
`endif
endmodule

// File: tb/tb_cam_core.sv
// tb_cam_core: directed scoreboard bench for cam_core
module tb_cam_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  update_req_index = '0;
    logic [31:0] update_req_data = '0;
    logic        update_req_valid = 1'b0;
    logic        update_req_ready;
    logic [3:0]  update_req_user = '0;
    logic [7:0]  lookup_req_index = '0;
    logic        lookup_req_valid = 1'b0;
    logic        lookup_req_ready;
    logic [3:0]  lookup_req_user = '0;
    logic [31:0] lookup_value_data;
    logic        lookup_value_valid;
    logic        lookup_value_ready = 1'b1;
    logic [3:0]  lookup_value_user;
    logic [4:0]  occupancy;
`ifdef CAM_CORE_HIT_EN
    logic        lookup_value_hit;
`endif

    typedef struct {
        logic [31:0] d;
        logic [3:0]  u;
        logic        h;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;

    cam_core dut (
        .clk(clk), .rst(rst),
        .update_req_index(update_req_index), .update_req_data(update_req_data),
        .update_req_valid(update_req_valid), .update_req_ready(update_req_ready),
        .update_req_user(update_req_user),
        .lookup_req_index(lookup_req_index), .lookup_req_valid(lookup_req_valid),
        .lookup_req_ready(lookup_req_ready), .lookup_req_user(lookup_req_user),
        .lookup_value_data(lookup_value_data), .lookup_value_valid(lookup_value_valid),
        .lookup_value_ready(lookup_value_ready), .lookup_value_user(lookup_value_user),
`ifdef CAM_CORE_HIT_EN
        .lookup_value_hit(lookup_value_hit),
`endif
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && lookup_value_valid && lookup_value_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL resp_unexpected: got data 0x%0h with empty scoreboard", lookup_value_data);
            end else begin
                mon_e = q.pop_front();
                chk("resp_data", 64'(lookup_value_data), 64'(mon_e.d));
                chk("resp_user", 64'(lookup_value_user), 64'(mon_e.u));
`ifdef CAM_CORE_HIT_EN
                chk("resp_hit", 64'(lookup_value_hit), 64'(mon_e.h));
`endif
            end
        end
    end

    task automatic do_upd(input logic [7:0] k, input logic [31:0] d);
        update_req_valid = 1'b1;
        update_req_index = k;
        update_req_data  = d;
        update_req_user  = k[3:0];
        tick();
        update_req_valid = 1'b0;
    endtask

    task automatic do_lk(input logic [7:0] k, input logic [3:0] u, input logic [31:0] d, input logic h);
        chk("lk_req_ready", 64'(lookup_req_ready), 64'd1);
        lookup_req_valid = 1'b1;
        lookup_req_index = k;
        lookup_req_user  = u;
        q.push_back('{d, u, h});
        tick();
        lookup_req_valid = 1'b0;
        chk("lk_latency_valid", 64'(lookup_value_valid), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        chk("rst_upd_ready", 64'(update_req_ready), 64'd0);
        chk("rst_lk_ready", 64'(lookup_req_ready), 64'd0);
        chk("rst_valid", 64'(lookup_value_valid), 64'd0);
        chk("rst_data", 64'(lookup_value_data), 64'd0);
        chk("rst_user", 64'(lookup_value_user), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        rst = 1'b0;
        #1;
        chk("upd_ready", 64'(update_req_ready), 64'd1);

        do_upd(8'h11, 32'hDEADBEEF);
        tick();
        do_lk(8'h11, 4'd3, 32'hDEADBEEF, 1'b1);
        chk("occ_one", 64'(occupancy), 64'd1);
        do_lk(8'h42, 4'd5, 32'h0, 1'b0);

        do_upd(8'h11, 32'd1);
        do_upd(8'h11, 32'd2);
        chk("occ_overwrite", 64'(occupancy), 64'd1);
        do_lk(8'h11, 4'd7, 32'd2, 1'b1);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("occ_cleared", 64'(occupancy), 64'd0);
        for (int i = 0; i < 16; i++)
            do_upd(8'(i), 32'h100 + 32'(i));
        chk("occ_full", 64'(occupancy), 64'd16);
        do_upd(8'h20, 32'h99);
        chk("occ_evict", 64'(occupancy), 64'd16);
        do_lk(8'h00, 4'd1, 32'h0, 1'b0);
        do_lk(8'h20, 4'd2, 32'h99, 1'b1);
        do_lk(8'h01, 4'd3, 32'h101, 1'b1);
        do_upd(8'h21, 32'h77);
        do_lk(8'h01, 4'd4, 32'h0, 1'b0);
        do_lk(8'h02, 4'd5, 32'h102, 1'b1);
        do_lk(8'h21, 4'd6, 32'h77, 1'b1);

        do_upd(8'h05, 32'd3);
        update_req_valid = 1'b1;
        update_req_index = 8'h05;
        update_req_data  = 32'd7;
        do_lk(8'h05, 4'd8, 32'd3, 1'b1);
        update_req_valid = 1'b0;
        do_lk(8'h05, 4'd9, 32'd7, 1'b1);
        chk("occ_after_rbw", 64'(occupancy), 64'd16);
        tick();

        lookup_value_ready = 1'b0;
        do_lk(8'h02, 4'd9, 32'h102, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_req_ready", 64'(lookup_req_ready), 64'd0);
            chk("hold_valid", 64'(lookup_value_valid), 64'd1);
            chk("hold_data", 64'(lookup_value_data), 64'h102);
            chk("hold_user", 64'(lookup_value_user), 64'd9);
            tick();
        end
        lookup_value_ready = 1'b1;
        tick();
        tick();

        lookup_value_ready = 1'b0;
        do_lk(8'h21, 4'd10, 32'h77, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("hold2_data", 64'(lookup_value_data), 64'h77);
            chk("hold2_req_ready", 64'(lookup_req_ready), 64'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        chk("midrst_valid", 64'(lookup_value_valid), 64'd0);
        chk("midrst_occ", 64'(occupancy), 64'd0);
        chk("midrst_lk_ready", 64'(lookup_req_ready), 64'd0);
        q.delete();
        rst = 1'b0;
        lookup_value_ready = 1'b1;
        #1;
        do_lk(8'h21, 4'd11, 32'h0, 1'b0);
        tick();
        tick();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
